ram_burst_ctrl: RTL and testbench

- Request-side controller sitting directly upstream of the 64x4 RAM_memory block.
- Accepts single or burst read/write requests over a valid/ready handshake and sequences them into RAM Enable/ReadWrite/Address/DataIn cycles.
- Captures RAM DataOut and returns read beats over a second valid/ready handshake.
- Burst addresses increment and wrap modulo 64.

---
 rtl/ram_ctrl_pkg.sv | 22 ++
 rtl/ram_addr_counter.sv | 46 ++++
 rtl/ram_burst_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller and its address counter.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned LEN_W_DEF  = 4;
  localparam int unsigned RAM_DEPTH  = 64;

  // RAM ReadWrite pin encodings
  localparam logic RAM_RD = 1'b1;
  localparam logic RAM_WR = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StWrWait,
    StWrDo,
    StRdDo,
    StRdCap,
    StRdResp
  } ctrl_state_e;

endpackage

// File: rtl/ram_addr_counter.sv
// Burst address/beat tracker: loads start address and length, steps with wrap at Depth,
// and flags the final beat.
module ram_addr_counter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W_DEF,
  parameter int unsigned LenW  = LEN_W_DEF,
  parameter int unsigned Depth = RAM_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [AddrW-1:0] start_addr_i,
  input  logic [LenW-1:0]  len_i,
  input  logic             step_i,
  output logic [AddrW-1:0] addr_o,
  output logic [AddrW-1:0] addr_next_o,
  output logic             last_o
);

  logic [AddrW-1:0] addr_q;
  logic [LenW-1:0]  remaining_q;
  logic [AddrW-1:0] addr_inc;

  always_comb begin
    addr_inc = (addr_q == AddrW'(Depth - 1)) ? '0 : addr_q + AddrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (load_i) begin
      addr_q      <= start_addr_i;
      remaining_q <= len_i;
    end else if (step_i) begin
      addr_q      <= addr_inc;
      remaining_q <= remaining_q - LenW'(1);
    end
  end

  assign addr_o      = addr_q;
  assign addr_next_o = addr_inc;
  assign last_o      = (remaining_q == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Request-side burst controller for the 64x4 RAM: sequences single/burst read and write
// requests into registered RAM Enable/ReadWrite/Address/DataIn cycles and returns read beats.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [LEN_W-1:0]  ReqLen,
  input  logic              WrValid,
  output logic              WrReady,
  input  logic [DATA_W-1:0] WrData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspLast,
  output logic              Busy,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut
);

  ctrl_state_e       state_q;
  logic              req_ready_q;
  logic              wr_ready_q;
  logic              rsp_valid_q;
  logic              rsp_last_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              busy_q;
  logic              mem_en_q;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;

  logic              ctr_load;
  logic              ctr_step;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic              last;

  always_comb begin
    ctr_load = (state_q == StIdle) && ReqValid;
    ctr_step = !last && ((state_q == StWrDo) || ((state_q == StRdResp) && RspReady));
  end

  ram_addr_counter #(
    .AddrW (ADDR_W),
    .LenW  (LEN_W),
    .Depth (RAM_DEPTH)
  ) u_addr_counter (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (ctr_load),
    .start_addr_i (ReqAddr),
    .len_i        (ReqLen),
    .step_i       (ctr_step),
    .addr_o       (addr),
    .addr_next_o  (addr_next),
    .last_o       (last)
  );

  // Enable and ReadWrite always move together so ReadWrite is never low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= RAM_RD;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ReqValid) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (ReqWrite) begin
              state_q    <= StWrWait;
              wr_ready_q <= 1'b1;
            end else begin
              state_q    <= StRdDo;
              mem_en_q   <= 1'b1;
              mem_rw_q   <= RAM_RD;
              mem_addr_q <= ReqAddr;
            end
          end
        end
        StWrWait: begin
          if (WrValid) begin
            wr_ready_q <= 1'b0;
            mem_din_q  <= WrData;
            mem_addr_q <= addr;
            mem_en_q   <= 1'b1;
            mem_rw_q   <= RAM_WR;
            state_q    <= StWrDo;
          end
        end
        StWrDo: begin
          mem_en_q <= 1'b0;
          mem_rw_q <= RAM_RD;
          if (last) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q    <= StWrWait;
            wr_ready_q <= 1'b1;
          end
        end
        StRdDo: begin
          state_q <= StRdCap;
        end
        StRdCap: begin
          rsp_data_q  <= MemDataOut;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= last;
          mem_en_q    <= 1'b0;
          state_q     <= StRdResp;
        end
        StRdResp: begin
          if (RspReady) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (last) begin
              state_q     <= StIdle;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              // Counter steps on this same edge, so issue the incremented address now.
              state_q    <= StRdDo;
              mem_en_q   <= 1'b1;
              mem_rw_q   <= RAM_RD;
              mem_addr_q <= addr_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ReqReady     = req_ready_q;
  assign WrReady      = wr_ready_q;
  assign RspValid     = rsp_valid_q;
  assign RspLast      = rsp_last_q;
  assign RspData      = rsp_data_q;
  assign Busy         = busy_q;
  assign MemEnable    = mem_en_q;
  assign MemReadWrite = mem_rw_q;
  assign MemAddress   = mem_addr_q;
  assign MemDataIn    = mem_din_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl: a 64x4 RAM model, a reference memory updated at
// request issue, and a negedge monitor that pops expected write commits and read beats.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ReqValid, ReqReady, ReqWrite;
  logic [5:0] ReqAddr;
  logic [3:0] ReqLen;
  logic       WrValid, WrReady;
  logic [3:0] WrData;
  logic       RspValid, RspReady, RspLast;
  logic [3:0] RspData;
  logic       Busy, MemEnable, MemReadWrite;
  logic [5:0] MemAddress;
  logic [3:0] MemDataIn, MemDataOut;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } rsp_t;

  rsp_t       exp_rsp[$];
  logic [9:0] exp_wr[$];
  logic [3:0] ram [64];
  logic [3:0] ref_mem [64];
  logic [3:0] wbuf [16];
  int         checks = 0;
  int         failures = 0;
  int         rdy_mode = 1;  // 0 random, 1 held high, 2 held low
  logic       hold;
  logic [3:0] hold_data;
  logic       hold_last;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqAddr      (ReqAddr),
    .ReqLen       (ReqLen),
    .WrValid      (WrValid),
    .WrReady      (WrReady),
    .WrData       (WrData),
    .RspValid     (RspValid),
    .RspReady     (RspReady),
    .RspData      (RspData),
    .RspLast      (RspLast),
    .Busy         (Busy),
    .MemEnable    (MemEnable),
    .MemReadWrite (MemReadWrite),
    .MemAddress   (MemAddress),
    .MemDataIn    (MemDataIn),
    .MemDataOut   (MemDataOut)
  );

  // RAM model: commits on the posedge ending an enabled write cycle.
  always @(posedge clk) begin
    if (MemEnable && !MemReadWrite) ram[MemAddress] <= MemDataIn;
  end
  assign MemDataOut = (MemEnable && MemReadWrite) ? ram[MemAddress] : 4'h0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       RspReady = 1'($urandom_range(0, 1));
      1:       RspReady = 1'b1;
      default: RspReady = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    rsp_t       r;
    logic [9:0] w;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("bp_valid_stable", int'(RspValid), 1);
        chk("bp_data_stable", int'(RspData), int'(hold_data));
        chk("bp_last_stable", int'(RspLast), int'(hold_last));
      end
      if (RspValid) chk("mem_idle_during_rsp", int'(MemEnable), 0);
      if (!MemEnable) chk("rw_high_when_disabled", int'(MemReadWrite), 1);
      if (RspValid && RspReady) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_data", int'(RspData), int'(r.data));
          chk("rsp_last", int'(RspLast), int'(r.last));
        end
      end
      if (MemEnable && !MemReadWrite) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", int'(MemAddress), int'(w[9:4]));
          chk("wr_data", int'(MemDataIn), int'(w[3:0]));
        end
      end
      hold      = RspValid && !RspReady;
      hold_data = RspData;
      hold_last = RspLast;
    end
  end

  // Returns at the negedge where the request handshake is visible.
  task automatic issue(input bit wr, input int addr, input int len);
    int t;
    @(negedge clk);
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = 6'(addr);
    ReqLen   = 4'(len);
    t = 0;
    while (!ReqReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("req_accept_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (Busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) chk("idle_timeout", 1, 0);
  endtask

  // stall_beat < 0 selects random 0..2 cycle gaps on every beat.
  task automatic run_write(input int addr, input int len, input int stall_beat,
                           input int stall, input bit rnd_data);
    int         a, t, dly;
    logic [3:0] d;
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % 64;
      d = rnd_data ? 4'($urandom) : wbuf[i];
      wbuf[i] = d;
      ref_mem[a] = d;
      exp_wr.push_back({6'(a), d});
    end
    issue(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      t = 0;
      @(negedge clk);
      ReqValid = 1'b0;
      WrValid  = 1'b0;
      while (!WrReady && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("wr_ready_timeout", 1, 0);
      dly = (i == stall_beat) ? stall : (stall_beat < 0 ? $urandom_range(0, 2) : 0);
      for (int k = 0; k < dly; k++) begin
        chk("stall_wr_ready", int'(WrReady), 1);
        chk("stall_mem_idle", int'(MemEnable), 0);
        if (i == stall_beat) begin
          chk("stall_busy", int'(Busy), 1);
          chk("stall_req_ready", int'(ReqReady), 0);
          ReqValid = 1'b1;
          ReqWrite = 1'b0;
          ReqAddr  = 6'($urandom);
        end
        @(negedge clk);
      end
      ReqValid = 1'b0;
      WrValid  = 1'b1;
      WrData   = wbuf[i];
    end
    @(negedge clk);
    WrValid = 1'b0;
    wait_idle(50);
  endtask

  // timed: RspReady held high, checks 3-cycle first-beat and beat-to-beat spacing.
  task automatic run_read(input int addr, input int len, input bit timed);
    int n;
    for (int i = 0; i <= len; i++) begin
      exp_rsp.push_back('{data: ref_mem[(addr + i) % 64], last: (i == len)});
    end
    issue(1'b0, addr, len);
    if (timed) begin
      for (int i = 0; i <= len; i++) begin
        n = 0;
        do begin
          @(negedge clk);
          ReqValid = 1'b0;
          n++;
        end while (!RspValid && n < 50);
        chk(i == 0 ? "rd_first_latency" : "rd_beat_spacing", n, 3);
      end
    end
    @(negedge clk);
    ReqValid = 1'b0;
    wait_idle(2000);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqLen = '0;
    WrValid = 1'b0; WrData = '0; RspReady = 1'b1;
    hold = 1'b0; hold_data = '0; hold_last = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", int'(ReqReady), 1);
    chk("rst_wr_ready", int'(WrReady), 0);
    chk("rst_rsp_valid", int'(RspValid), 0);
    chk("rst_rsp_last", int'(RspLast), 0);
    chk("rst_rsp_data", int'(RspData), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_mem_en", int'(MemEnable), 0);
    chk("rst_mem_rw", int'(MemReadWrite), 1);
    chk("rst_mem_addr", int'(MemAddress), 0);
    chk("rst_mem_din", int'(MemDataIn), 0);
    rst_n = 1'b1;

    // Single write then single read
    wbuf[0] = 4'hA;
    run_write(5, 0, 0, 0, 1'b0);
    run_read(5, 0, 1'b1);

    // Wrapping burst 62,63,0,1
    wbuf[0] = 4'hA; wbuf[1] = 4'hB; wbuf[2] = 4'hC; wbuf[3] = 4'hD;
    run_write(62, 3, 0, 0, 1'b0);
    run_read(62, 3, 1'b1);

    // Backpressure on the first beat of a 2-beat read
    rdy_mode = 2;
    exp_rsp.push_back('{data: ref_mem[63], last: 1'b0});
    exp_rsp.push_back('{data: ref_mem[0], last: 1'b1});
    issue(1'b0, 63, 1);
    n = 0;
    do begin
      @(negedge clk);
      ReqValid = 1'b0;
      n++;
    end while (!RspValid && n < 50);
    chk("bp_first_valid", int'(RspValid), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(RspValid), 1);
      chk("bp_hold_data", int'(RspData), int'(ref_mem[63]));
      chk("bp_no_next_beat", int'(MemEnable), 0);
    end
    rdy_mode = 1;
    wait_idle(100);

    // Write stall of 4 cycles on beat 2, with an ignored request presented meanwhile
    run_write(10, 3, 2, 4, 1'b1);
    run_read(10, 3, 1'b1);

    // Reset during beat 2 of a 4-beat read
    for (int i = 0; i < 4; i++) exp_rsp.push_back('{data: ref_mem[(20 + i) % 64], last: (i == 3)});
    issue(1'b0, 20, 3);
    n = 0;
    do begin
      @(negedge clk);
      ReqValid = 1'b0;
      n++;
    end while (!RspValid && n < 50);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", int'(RspValid), 0);
    chk("midrst_mem_en", int'(MemEnable), 0);
    chk("midrst_mem_rw", int'(MemReadWrite), 1);
    chk("midrst_busy", int'(Busy), 0);
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", int'(ReqReady), 1);
    chk("postrst_busy", int'(Busy), 0);
    run_read(20, 1, 1'b1);

    // Random traffic against the reference memory
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        rdy_mode = 1;
        run_write($urandom_range(0, 63), $urandom_range(0, 7), -1, 0, 1'b1);
      end else begin
        rdy_mode = 0;
        run_read($urandom_range(0, 63), $urandom_range(0, 7), 1'b0);
      end
    end
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
